clock_tick_ctrl: RTL and testbench
==================================

Name: clock_tick_ctrl

Overview:
Sequencer for the digital-clock counter chain. It generates the per-unit enables for four external mod-N counters: seconds mod 60, minutes mod 60, hours mod 24, day-of-week mod 7. It prescales the system clock into a seconds tick and ripples carries using each counter's max flag. It also runs a button-driven set-time FSM that advances one unit at a time with no carry.

Parameters:
TICK_DIV, 1_000_000, system clock cycles per seconds tick (>=2)
SET_TIMEOUT, 10_000_000, idle clock cycles in any SET state before auto-return to RUN (>=2)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
mode_btn  input  1  raw asynchronous mode button, active-high
adv_btn  input  1  raw asynchronous advance button, active-high
sec_max  input  1  seconds counter at modulus-1
min_max  input  1  minutes counter at modulus-1
hr_max  input  1  hours counter at modulus-1
sec_en  output  1  seconds counter increment enable
min_en  output  1  minutes counter increment enable
hr_en  output  1  hours counter increment enable
day_en  output  1  day counter increment enable
sec_clr  output  1  one-cycle clear pulse for the seconds counter's synchronous reset
mode  output  2  current mode_t: RUN=0, SET_MIN=1, SET_HR=2, SET_DAY=3

Behaviour:
- Reset (async, active-high) forces these values immediately: state=RUN, prescaler=0, timeout counter=0, synchronizer/edge flops=0. All enables and sec_clr read 0 while rst is high.
- Prescaler: counts 0..TICK_DIV-1 in RUN only. tick = (pre==TICK_DIV-1), combinational. pre wraps to 0 after TICK_DIV-1. In SET states pre is held at 0.
- RUN enables (combinational, same cycle as tick): sec_en=tick; min_en=tick&sec_max; hr_en=tick&sec_max&min_max; day_en=tick&sec_max&min_max&hr_max.
- Max inputs are sampled in the cycle the enable is asserted. Counters wrap themselves.
- Buttons: each goes through a 2-flop synchronizer plus a rising-edge detector, producing a one-cycle pulse (mode_p / adv_p). A held button yields exactly one pulse. Pulse latency is 3 posedges from the first edge that samples the button high.
- FSM on mode_p: RUN->SET_MIN->SET_HR->SET_DAY->RUN.
- sec_clr is a one-cycle pulse on the RUN->SET_MIN transition, asserted in the first cycle mode==SET_MIN.
- SET states: sec_en=0, and carries are disabled.
  - adv_p in SET_MIN drives min_en=1 for that cycle only.
  - adv_p in SET_HR drives hr_en=1 for that cycle only.
  - adv_p in SET_DAY drives day_en=1 for that cycle only.
  - No other enable fires, regardless of max inputs.
- adv_p in RUN is ignored.
- Simultaneous mode_p and adv_p: mode transition wins and adv_p is dropped (no enable).
- Timeout: in SET states, the counter clears on any mode_p/adv_p and on entry. When it reaches SET_TIMEOUT-1, the next state is RUN.
- On any return to RUN, pre restarts at 0, so the first tick comes TICK_DIV cycles later.
- mode is the registered state; it changes one cycle after the triggering pulse.
- Reset mid-SET: immediate RUN, no sec_clr, no enables.

Decomposition:
- Package clock_pkg holds:
  - typedef enum logic[1:0] mode_t {RUN, SET_MIN, SET_HR, SET_DAY}
  - constants SEC_MOD=60, MIN_MOD=60, HR_MOD=24, DAY_MOD=7, for whoever instantiates the counters
- One sub-module, btn_edge: 2-flop synchronizer plus rising-edge pulse, with clk/rst/btn_in/pulse. Instantiated twice.
- Prescaler, timeout counter and FSM stay in clock_tick_ctrl.

Test Plan:
1. TICK_DIV=4, release rst, all max=0 -> sec_en high exactly on cycles 4, 8, 12 after release; min_en/hr_en/day_en stay 0.
2. RUN with sec_max=1, min_max=1, hr_max=0 at a tick -> sec_en=min_en=hr_en=1 and day_en=0 in that same cycle. Repeat with hr_max=1 -> all four enables high.
3. Press mode_btn 4 times (10-cycle pulses, separated) -> mode 0->1->2->3->0. sec_clr is a single 1-cycle pulse on entering 1. sec_en=0 throughout SET states.
4. In SET_HR with sec_max=min_max=hr_max=1, hold adv_btn 8 cycles -> exactly one hr_en pulse. sec_en/min_en/day_en stay 0.
5. SET_TIMEOUT=20: enter SET_MIN, no buttons -> mode returns to 0 after 20 cycles, then first sec_en 4 cycles later. An adv press at cycle 15 delays the return to 20 cycles after that press.
6. In SET_MIN, assert mode_btn and adv_btn together -> mode=2 and min_en never asserted. Then assert rst mid-SET_HR -> mode=0 and all enables 0 with no clock edge needed.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock sequencer and the
// counter chain it drives.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_HR  = 2'd2,
    SET_DAY = 2'd3
  } mode_t;

  // Moduli for the external counters; the sequencer itself only sees their max flags.
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HR_MOD  = 24;
  localparam int DAY_MOD = 7;

endpackage

// File: rtl/clock_tick_ctrl_if.sv
// Strobe/flag bundle between the tick sequencer (master) and the
// counter chain (slave).
interface clock_tick_ctrl_if;
  // Each *_en and sec_clr is a one-cycle, clk-qualified strobe; each *_max is a
  // level that is only looked at in the cycle a strobe is high. There is no back-pressure.
  logic sec_max;
  logic min_max;
  logic hr_max;
  logic sec_en;
  logic min_en;
  logic hr_en;
  logic day_en;
  logic sec_clr;

  modport master (
    input  sec_max, min_max, hr_max,
    output sec_en, min_en, hr_en, day_en, sec_clr
  );

  modport slave (
    output sec_max, min_max, hr_max,
    input  sec_en, min_en, hr_en, day_en, sec_clr
  );
endinterface

// File: rtl/clock_tick_ctrl_btn_edge.sv
// Two-flop synchronizer for a raw button plus a registered rising-edge pulse;
// a held button yields one pulse, three posedges after it is first sampled high.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse
);
  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end
endmodule

// File: rtl/clock_tick_ctrl.sv
// Digital-clock sequencer: prescales clk into a seconds tick, ripples carries
// through the counter max flags, and runs the button-driven set-time FSM.
module clock_tick_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1_000_000,
  parameter int unsigned SET_TIMEOUT = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_btn,
  input  logic              adv_btn,
  clock_tick_ctrl_if.master cnt,
  output mode_t             mode
);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int TO_W  = $clog2(SET_TIMEOUT);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_MIN = 2'd1;
  localparam logic [1:0] ST_SET_HR  = 2'd2;
  localparam logic [1:0] ST_SET_DAY = 2'd3;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [PRE_W-1:0] pre_q;
  logic [TO_W-1:0]  to_q;
  logic             clr_q;
  logic             mode_p;
  logic             adv_p;
  logic             in_run;
  logic             tick;
  logic             timeout;
  logic             adv_ok;

  btn_edge u_mode_edge (.clk(clk), .rst(rst), .btn_in(mode_btn), .pulse(mode_p));
  btn_edge u_adv_edge  (.clk(clk), .rst(rst), .btn_in(adv_btn),  .pulse(adv_p));

  assign in_run  = (state_q == ST_RUN);
  assign tick    = in_run && (pre_q == PRE_W'(TICK_DIV - 1));
  assign timeout = !in_run && (to_q == TO_W'(SET_TIMEOUT - 1));
  // A mode press in the same cycle as an advance press swallows the advance.
  assign adv_ok  = adv_p & ~mode_p;

  always_comb begin
    state_d = state_q;
    if (mode_p)       state_d = state_q + 2'd1;
    else if (timeout) state_d = ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pre_q   <= '0;
      to_q    <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Held at zero outside RUN so the first tick after returning is a full period away.
      if (!in_run || tick) pre_q <= '0;
      else                 pre_q <= pre_q + 1'b1;
      if (in_run || mode_p || adv_p) to_q <= '0;
      else                           to_q <= to_q + 1'b1;
      clr_q <= in_run && (state_d == ST_SET_MIN);
    end
  end

  assign cnt.sec_en  = tick;
  assign cnt.min_en  = (tick & cnt.sec_max)
                     | ((state_q == ST_SET_MIN) & adv_ok);
  assign cnt.hr_en   = (tick & cnt.sec_max & cnt.min_max)
                     | ((state_q == ST_SET_HR) & adv_ok);
  assign cnt.day_en  = (tick & cnt.sec_max & cnt.min_max & cnt.hr_max)
                     | ((state_q == ST_SET_DAY) & adv_ok);
  assign cnt.sec_clr = clr_q;
  assign mode        = mode_t'(state_q);

endmodule

// File: tb/tb_clock_tick_ctrl.sv
// Self-checking bench for clock_tick_ctrl: directed scenarios plus a random
// button/flag phase, all compared each cycle against a cycle-stamp model.
module tb_clock_tick_ctrl;
  import clock_pkg::*;

  localparam int TD = 4;
  localparam int TO = 20;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  mode_btn = 1'b0;
  logic  adv_btn = 1'b0;
  mode_t mode;

  clock_tick_ctrl_if cnt ();

  clock_tick_ctrl #(.TICK_DIV(TD), .SET_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .adv_btn(adv_btn),
    .cnt(cnt), .mode(mode)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tb_cyc = 0;
  always @(posedge clk) tb_cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Works with cycle stamps: when RUN was (re)entered, when the idle count last
  // restarted, and the sampled history of each button.
  int m_cyc = 0;
  int m_run_start = 0;
  int m_last_act = 0;
  int m_mode = 0;
  bit m_clr = 1'b0;
  bit m_mp = 1'b0;
  bit m_ap = 1'b0;
  bit mq[$] = '{1'b0, 1'b0, 1'b0, 1'b0};
  bit aq[$] = '{1'b0, 1'b0, 1'b0, 1'b0};

  always @(posedge clk or posedge rst) begin : model
    int nm;
    if (rst) begin
      m_cyc = 0; m_run_start = 0; m_last_act = 0; m_mode = 0;
      m_clr = 1'b0; m_mp = 1'b0; m_ap = 1'b0;
      mq = '{1'b0, 1'b0, 1'b0, 1'b0};
      aq = '{1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      if (m_mp) nm = (m_mode + 1) % 4;
      else if (m_mode != 0 && (m_cyc - m_last_act) == TO - 1) nm = 0;
      else nm = m_mode;
      if (m_mode == 0 || m_mp || m_ap) m_last_act = m_cyc + 1;
      if (m_mode != 0) m_run_start = m_cyc + 1;
      m_clr = (m_mode == 0) && (nm == 1);
      m_mode = nm;
      m_cyc++;
      mq.push_back(mode_btn); void'(mq.pop_front());
      aq.push_back(adv_btn);  void'(aq.pop_front());
      // Pulse appears when the sample from two edges ago is high and the one before it low.
      m_mp = mq[1] && !mq[0];
      m_ap = aq[1] && !aq[0];
    end
  end

  function automatic logic [6:0] model_vec();
    bit tick, sm, mm, hm, ok;
    bit sec, mn, hr, day;
    tick = (m_mode == 0) && (((m_cyc - m_run_start) % TD) == TD - 1);
    sm = cnt.sec_max; mm = cnt.min_max; hm = cnt.hr_max;
    ok = m_ap && !m_mp;
    sec = tick;
    mn  = (tick && sm) || (m_mode == 1 && ok);
    hr  = (tick && sm && mm) || (m_mode == 2 && ok);
    day = (tick && sm && mm && hm) || (m_mode == 3 && ok);
    return {2'(m_mode), sec, mn, hr, day, m_clr};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {2'(mode), cnt.sec_en, cnt.min_en, cnt.hr_en, cnt.day_en, cnt.sec_clr};
  endfunction

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];

  always @(posedge clk) begin
    #4;
    if (!rst && chk_on) exp_q.push_back(model_vec());
  end

  always @(negedge clk) begin
    logic [6:0] e;
    logic [6:0] a;
    if (!rst && chk_on) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        a = dut_vec();
        n_total++;
        if (a == e) n_pass++;
        else $display("FAIL cycle_outputs cyc=%0d: got %b, want %b", tb_cyc, a, e);
      end
    end
  end

  // ---------------- event monitor ----------------
  int cnt_sec = 0, cnt_min = 0, cnt_hr = 0, cnt_day = 0, cnt_clr = 0, cnt_sec_set = 0;
  int last_min_cyc = -1;

  always @(negedge clk) begin
    if (!rst) begin
      if (cnt.sec_en) cnt_sec++;
      if (cnt.min_en) begin cnt_min++; last_min_cyc = tb_cyc; end
      if (cnt.hr_en) cnt_hr++;
      if (cnt.day_en) cnt_day++;
      if (cnt.sec_clr) cnt_clr++;
      if (cnt.sec_en && mode != RUN) cnt_sec_set++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_n(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_counts();
    cnt_sec = 0; cnt_min = 0; cnt_hr = 0; cnt_day = 0; cnt_clr = 0; cnt_sec_set = 0;
  endtask

  task automatic set_max(input bit s, input bit m, input bit h);
    cnt.sec_max = s; cnt.min_max = m; cnt.hr_max = h;
  endtask

  task automatic press_mode(input int len, input int gap);
    mode_btn = 1'b1; tick_n(len); mode_btn = 1'b0; tick_n(gap);
  endtask

  task automatic wait_mode(input int target, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (int'(mode) == target) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_sec_en(output bit found);
    found = 1'b0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      if (cnt.sec_en) begin found = 1'b1; break; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  hits[$];
    int  other;
    bit  found;
    int  t_e, t_r, t_s;

    set_max(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'(dut_vec()), 0);

    // Ticks on the 4th, 8th and 12th cycle after release, no carries.
    @(posedge clk); #2;
    rst = 1'b0; chk_on = 1'b1;
    other = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (cnt.sec_en) hits.push_back(i);
      if (cnt.min_en || cnt.hr_en || cnt.day_en) other++;
    end
    check("tick_count", hits.size(), 3);
    check("tick_first_cycle", (hits.size() > 0) ? hits[0] : -1, 3);
    check("tick_third_cycle", (hits.size() > 2) ? hits[2] : -1, 11);
    check("no_carry_without_max", other, 0);

    // Carry ripple at a tick.
    tick_n(1);
    set_max(1'b1, 1'b1, 1'b0);
    wait_sec_en(found);
    check("carry_tick_seen", found, 1);
    check("carry_min_en", cnt.min_en, 1);
    check("carry_hr_en", cnt.hr_en, 1);
    check("carry_day_en_blocked", cnt.day_en, 0);
    tick_n(1);
    set_max(1'b1, 1'b1, 1'b1);
    wait_sec_en(found);
    check("carry_all_tick_seen", found, 1);
    check("carry_all_four", {cnt.sec_en, cnt.min_en, cnt.hr_en, cnt.day_en}, 4'b1111);
    tick_n(1);
    set_max(1'b0, 1'b0, 1'b0);

    // Mode cycling through all states.
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      press_mode(10, 6);
      check($sformatf("mode_after_press%0d", k), int'(mode), (k + 1) % 4);
    end
    check("sec_clr_pulses", cnt_clr, 1);
    check("sec_en_in_set", cnt_sec_set, 0);

    // Held advance in SET_HR: one hr_en, nothing else, even with all max flags up.
    press_mode(10, 6);
    press_mode(10, 6);
    check("mode_set_hr", int'(mode), 2);
    set_max(1'b1, 1'b1, 1'b1);
    clear_counts();
    adv_btn = 1'b1; tick_n(8); adv_btn = 1'b0; tick_n(6);
    check("set_hr_hr_en", cnt_hr, 1);
    check("set_hr_sec_en", cnt_sec, 0);
    check("set_hr_min_en", cnt_min, 0);
    check("set_hr_day_en", cnt_day, 0);
    wait_mode(0, 40, found);
    check("set_hr_timeout_seen", found, 1);
    tick_n(1);
    set_max(1'b0, 1'b0, 1'b0);

    // Idle timeout from SET_MIN, then first tick a full period after return.
    mode_btn = 1'b1;
    wait_mode(1, 10, found);
    check("enter_set_min", found, 1);
    t_e = tb_cyc;
    tick_n(1); mode_btn = 1'b0;
    wait_mode(0, 40, found);
    t_r = tb_cyc;
    check("timeout_seen", found, 1);
    check("timeout_len", t_r - t_e, 20);
    wait_sec_en(found);
    t_s = tb_cyc;
    check("tick_after_timeout_seen", found, 1);
    // Counted from the last SET_MIN cycle.
    check("tick_after_timeout", t_s - (t_r - 1), 4);

    // An advance press 15 cycles into SET_MIN restarts the idle count.
    tick_n(1);
    clear_counts();
    mode_btn = 1'b1;
    wait_mode(1, 10, found);
    t_e = tb_cyc;
    tick_n(1); mode_btn = 1'b0;
    while (tb_cyc < t_e + 15) tick_n(1);
    adv_btn = 1'b1; tick_n(3); adv_btn = 1'b0;
    wait_mode(0, 60, found);
    t_r = tb_cyc;
    check("adv_timeout_seen", found, 1);
    check("adv_min_en_count", cnt_min, 1);
    check("adv_pulse_to_run", t_r - last_min_cyc, 21);
    check("adv_entry_to_run", t_r - t_e, 39);

    // Random buttons and max flags, checked by the model every cycle.
    tick_n(1);
    repeat (600) begin
      set_max(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) mode_btn = ~mode_btn;
      if ($urandom_range(0, 3) == 0) adv_btn = ~adv_btn;
      tick_n(1);
    end
    mode_btn = 1'b0; adv_btn = 1'b0;
    set_max(1'b0, 1'b0, 1'b0);
    tick_n(5);
    wait_mode(0, 80, found);
    check("random_return_run", found, 1);

    // Simultaneous mode+adv in SET_MIN: mode wins, no min_en.
    tick_n(1);
    mode_btn = 1'b1;
    wait_mode(1, 10, found);
    check("enter_set_min_2", found, 1);
    tick_n(1); mode_btn = 1'b0;
    tick_n(3);
    clear_counts();
    mode_btn = 1'b1; adv_btn = 1'b1;
    tick_n(4);
    mode_btn = 1'b0; adv_btn = 1'b0;
    tick_n(2);
    check("simul_mode", int'(mode), 2);
    check("simul_min_en", cnt_min, 0);
    check("simul_hr_en", cnt_hr, 0);

    // Asynchronous reset mid-SET_HR, checked before any clock edge.
    rst = 1'b1;
    #1;
    check("async_rst_mode", int'(mode), 0);
    check("async_rst_strobes", {cnt.sec_en, cnt.min_en, cnt.hr_en, cnt.day_en, cnt.sec_clr}, 0);
    tick_n(3);
    rst = 1'b0;
    tick_n(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
